fb_loader: RTL

Streaming frame-buffer writer for the panel image RAM. Accepts an 8-bit byte stream (valid/ready), locks on a sync byte, packs each R,G,B byte triple into a 24-bit pixel and writes it through the RAM's write port at sequential addresses 0..PIXELS-1. It sits between the host link receiver and port A of the 24-bit image RAM; port B remains the display side.

---
 rtl/fb_pkg.sv | 9 +
 rtl/fb_pixel_packer.sv | 38 +++
 rtl/fb_loader.sv | 109 ++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants and FSM state type for the fb_loader frame-buffer writer
package fb_pkg;
   localparam int         PIXELS    = 2304;
   localparam int         ADDR_W    = 12;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         PIX_W     = 24;

   typedef enum logic [1:0] {IDLE, R, G, B} fb_state_e;
endpackage

// File: rtl/fb_pixel_packer.sv
// rtl/fb_pixel_packer.sv - packs R,G,B bytes into a 24-bit pixel and drives the registered RAM write stage
module fb_pixel_packer
   import fb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        pix_byte,
   input  logic              take_r,
   input  logic              take_g,
   input  logic              take_b,
   input  logic [ADDR_W-1:0] index,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [PIX_W-1:0]  data
);
   logic [7:0] r_q;
   logic [7:0] g_q;

   // The B byte is folded in directly so the write lands exactly one cycle after it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q  <= '0;
         g_q  <= '0;
         we   <= 1'b0;
         addr <= '0;
         data <= '0;
      end else begin
         we <= 1'b0;
         if (take_r) r_q <= pix_byte;
         if (take_g) g_q <= pix_byte;
         if (take_b) begin
            we   <= 1'b1;
            addr <= index;
            data <= {r_q, g_q, pix_byte};
         end
      end
   end
endmodule

// File: rtl/fb_loader.sv
// rtl/fb_loader.sv - sync-locked byte stream to image RAM port A writer; FB_LOADER_TIMEOUT_EN enables mid-frame idle abort
module fb_loader
   import fb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              we_a,
   output logic [ADDR_W-1:0] addr_a,
   output logic [PIX_W-1:0]  data_in_a,
   output logic              frame_done,
   output logic              busy,
   output logic              err
);
   fb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              take, take_r, take_g, take_b, last_pix, timeout;

   assign in_ready = ~rst;
   assign take     = in_valid & in_ready;
   assign busy     = (state_q != IDLE);

`ifdef FB_LOADER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;

   assign timeout = busy && !take && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       to_cnt <= '0;
      else if (!busy || take || timeout) to_cnt <= '0;
      else                           to_cnt <= to_cnt + TO_W'(1);
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         frame_done <= last_pix;
         err        <= timeout;
      end
   end

   // A sync byte only matters in IDLE; inside a pixel it is ordinary colour data.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      take_r   = 1'b0;
      take_g   = 1'b0;
      take_b   = 1'b0;
      last_pix = 1'b0;
      case (state_q)
         IDLE: if (take && in_data == SYNC_BYTE) begin
            state_d = R;
            idx_d   = '0;
         end
         R: if (take) begin
            take_r  = 1'b1;
            state_d = G;
         end
         G: if (take) begin
            take_g  = 1'b1;
            state_d = B;
         end
         B: if (take) begin
            take_b = 1'b1;
            if (idx_q == ADDR_W'(PIXELS - 1)) begin
               state_d  = IDLE;
               idx_d    = '0;
               last_pix = 1'b1;
            end else begin
               state_d = R;
               idx_d   = idx_q + ADDR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (timeout) begin
         state_d = IDLE;
         idx_d   = '0;
      end
   end

   fb_pixel_packer u_packer (
      .clk      (clk),
      .rst      (rst),
      .pix_byte (in_data),
      .take_r   (take_r),
      .take_g   (take_g),
      .take_b   (take_b),
      .index    (idx_q),
      .we       (we_a),
      .addr     (addr_a),
      .data     (data_in_a)
   );
endmodule
